imem_loader: RTL and testbench
==============================

# imem_loader

Writes a byte stream (the puzzle hex transmission, already converted to bytes) into the 1024x32 instruction memory and reports the loaded length. It is the write-side counterpart of the instruction-memory read controller: it fills `imem_*` with big-endian packed words starting at word 0 and publishes `expectedBytes` for the reader and `bits_fsm`. It sits between the host/byte source and the instruction memory write port.

## Interface
- No parameters. Depth fixed at 1024 words (4096 bytes).
- `clk` input 1: system clock; all state updates on rising edge.
- `resetB` input 1: asynchronous, active-low reset.
- `load_start_b` input 1: active-low one-cycle strobe; begins a new load.
- `in_valid_b` input 1: active-low; `in_data` and `in_last` are valid.
- `in_data` input 8: stream byte.
- `in_last` input 1: qualifies the final byte of the stream.
- `in_ready_b` output 1: active-low; the loader accepts a byte this cycle.
- `imem_ceb` output 1: memory chip enable, active-low.
- `imem_web` output 1: memory write enable, active-low.
- `imem_addr` output 10: word address.
- `imem_wdata` output 32: write data.
- `imem_rdata` input 32: read data, one-cycle latency. Used only with the read-back feature and ignored otherwise.
- `expectedBytes` output 16: total bytes accepted in the current or last load.
- `load_done` output 1: sticky, high after a successful load.
- `load_error` output 1: sticky, high after overflow or read-back mismatch.

## Operation
- Byte handshake: a byte is accepted on the rising edge where `in_valid_b`=0 and `in_ready_b`=0.
- States and transitions:
  - IDLE → COLLECT on `load_start_b`=0. That edge clears the pack register, byte index, `imem_addr`, `expectedBytes`, `load_done` and `load_error`.
  - COLLECT: `in_ready_b`=0. Each accepted byte goes to lane `byte_idx`: idx0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0]. `byte_idx` and `expectedBytes` increment by 1. On byte_idx==3 or `in_last`=1 → WRITE.
  - WRITE: lasts one cycle with `imem_ceb`=0, `imem_web`=0, `imem_addr` = current word, `imem_wdata` = pack register. Lanes that were not written are zero-padded.
  - After WRITE: `imem_addr` increments (10-bit), pack register clears and `byte_idx` resets to 0. Next state is DONE if the word held the last byte, otherwise COLLECT.
  - DONE: `load_done`=1, `in_ready_b`=1. Returns to COLLECT only on `load_start_b`.
  - ERR: `load_error`=1, `in_ready_b`=1, no memory access. Leaves only on `load_start_b`.
- Overflow:
  - In COLLECT with `expectedBytes`==4096 and `in_valid_b`=0, the byte is not accepted and the state goes to ERR.
  - `imem_addr` never wraps to 0 with a write.
- `load_start_b` asserted in COLLECT or WRITE is ignored.
- `in_last` is ignored when `in_valid_b`=1.
- `expectedBytes` is 16 bits. The maximum legal value is 4096 (0x1000).

## Timing
- All outputs are registered.
- Reset values: `in_ready_b`=1, `imem_ceb`=1, `imem_web`=1, `imem_addr`=0, `imem_wdata`=0, `expectedBytes`=0, `load_done`=0, `load_error`=0, state IDLE.
- The 4th byte (or the `in_last` byte) is accepted at edge N. At the same edge N, `imem_ceb`/`imem_web` go low and `in_ready_b` goes high.
- At edge N+1: `imem_ceb`/`imem_web` go high, `imem_addr` increments, and `in_ready_b` returns low (or state enters DONE).
- Sustained throughput is 4 bytes per 5 cycles.
- `in_ready_b` goes low one cycle after `load_start_b` is sampled.
- `load_done` rises on the edge after the final WRITE cycle.
- Reset mid-load: all state and outputs return to reset values immediately. The partially packed word is discarded and never written.

## Configuration
- Macro: `IMEM_LOADER_READBACK_EN`.
- Defined:
  - After each WRITE, a VERIFY_RD cycle drives `imem_ceb`=0, `imem_web`=1 at the same address.
  - A VERIFY_CMP cycle then compares `imem_rdata` with the written word.
  - On mismatch: ERR. On match: `imem_addr` increments and the normal next state follows.
  - Throughput becomes 4 bytes per 7 cycles. `load_done` is delayed by 2 cycles.
- Undefined: no VERIFY states, `imem_rdata` unused, timing as above.

## Test plan
- Load 8A 00 4F 00 D2 FE 28 00 (`in_last` on 8th byte) → writes addr0=0x8A004F00, addr1=0xD2FE2800; `expectedBytes`=8; `load_done`=1.
- Load 5 bytes 38 00 6F 45 29 (`in_last` on 5th) → addr0=0x38006F45, addr1=0x29000000; `expectedBytes`=5.
- Hold `in_valid_b`=0 continuously for 12 bytes → `in_ready_b` high exactly during each of the 3 WRITE cycles; no byte dropped or duplicated; addr0..2 correct.
- Stream 4097 bytes with no `in_last` → 1024 writes (addr 0..1023), byte 4097 refused, `load_error`=1, no write to addr0 after wrap.
- Assert `resetB` low after 6 bytes → all outputs at reset values. A new load of 4 bytes then writes addr0 only.
- With `IMEM_LOADER_READBACK_EN`, force `imem_rdata`=0xDEADBEEF when 0x8A004F00 was written → `load_error`=1, `load_done`=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory port bundle for imem_loader.
// master = loader side, slave = byte source plus memory.
interface imem_loader_if;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  logic              in_valid_b;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              in_ready_b;
  logic              imem_ceb;
  logic              imem_web;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    input  in_valid_b, in_data, in_last, imem_rdata,
    output in_ready_b, imem_ceb, imem_web, imem_addr, imem_wdata
  );

  modport slave (
    output in_valid_b, in_data, in_last, imem_rdata,
    input  in_ready_b, imem_ceb, imem_web, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a byte stream big-endian into the 1024x32 instruction memory from word 0.
// Optional write read-back check: define IMEM_LOADER_READBACK_EN.
module imem_loader (
  input  logic                 clk,
  input  logic                 resetB,
  input  logic                 load_start_b,
  imem_loader_if.master        bus,
  output logic [15:0]          expectedBytes,
  output logic                 load_done,
  output logic                 load_error
);
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned MAX_BYTES = 4096;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
`ifdef IMEM_LOADER_READBACK_EN
    ,
    S_VRD     = 3'd5,
    S_VCMP    = 3'd6
`endif
  } state_t;

  state_t              r_state, w_state_nx;
  logic [DATA_W-1:0]   r_pack, w_pack_nx, w_pack_new, w_lane;
  logic [IDX_W-1:0]    r_idx, w_idx_nx;
  logic                r_last, w_last_nx;
  logic                r_ready_b, w_ready_b_nx;
  logic                r_ceb, w_ceb_nx;
  logic                r_web, w_web_nx;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nx;
  logic [CNT_W-1:0]    r_bytes, w_bytes_nx;
  logic                r_done, w_done_nx;
  logic                r_err, w_err_nx;
  logic                w_full, w_word_done, w_start;

`ifndef IMEM_LOADER_READBACK_EN
  logic w_unused_rdata;
  assign w_unused_rdata = ^bus.imem_rdata;
`endif

  assign w_full = (r_bytes == CNT_W'(MAX_BYTES));

  // Byte lane select: index 0 lands in the most significant byte.
  always_comb begin
    w_lane = '0;
    case (r_idx)
      2'd0:    w_lane = {bus.in_data, 24'h0};
      2'd1:    w_lane = {8'h0, bus.in_data, 16'h0};
      2'd2:    w_lane = {16'h0, bus.in_data, 8'h0};
      default: w_lane = {24'h0, bus.in_data};
    endcase
  end

  assign w_pack_new = r_pack | w_lane;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nx   = r_state;
    w_pack_nx    = r_pack;
    w_idx_nx     = r_idx;
    w_last_nx    = r_last;
    w_ready_b_nx = r_ready_b;
    w_ceb_nx     = 1'b1;
    w_web_nx     = 1'b1;
    w_addr_nx    = r_addr;
    w_wdata_nx   = r_wdata;
    w_bytes_nx   = r_bytes;
    w_done_nx    = r_done;
    w_err_nx     = r_err;
    w_word_done  = 1'b0;
    w_start      = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: w_start = !load_start_b;
      S_COLLECT: begin
        if (!bus.in_valid_b) begin
          if (w_full) begin
            w_state_nx   = S_ERR;
            w_err_nx     = 1'b1;
            w_ready_b_nx = 1'b1;
          end else if (!r_ready_b) begin
            w_bytes_nx = r_bytes + CNT_W'(1);
            w_pack_nx  = w_pack_new;
            if (r_idx == IDX_W'(3) || bus.in_last) begin
              w_state_nx   = S_WRITE;
              w_ceb_nx     = 1'b0;
              w_web_nx     = 1'b0;
              w_wdata_nx   = w_pack_new;
              w_ready_b_nx = 1'b1;
              w_last_nx    = bus.in_last;
            end else begin
              w_idx_nx = r_idx + IDX_W'(1);
            end
          end
        end
      end
`ifdef IMEM_LOADER_READBACK_EN
      S_WRITE: begin
        w_state_nx = S_VRD;
        w_ceb_nx   = 1'b0;
      end
      S_VRD:   w_state_nx = S_VCMP;
      S_VCMP: begin
        if (bus.imem_rdata != r_wdata) begin
          w_state_nx = S_ERR;
          w_err_nx   = 1'b1;
        end else begin
          w_word_done = 1'b1;
        end
      end
`else
      S_WRITE: w_word_done = 1'b1;
`endif
      default: w_state_nx = S_IDLE;
    endcase

    // Word committed: advance address and start a fresh pack.
    if (w_word_done) begin
      w_addr_nx = r_addr + ADDR_W'(1);
      w_pack_nx = '0;
      w_idx_nx  = '0;
      if (r_last) begin
        w_state_nx   = S_DONE;
        w_done_nx    = 1'b1;
        w_ready_b_nx = 1'b1;
      end else begin
        w_state_nx   = S_COLLECT;
        w_ready_b_nx = w_full;
      end
    end

    if (w_start) begin
      w_state_nx   = S_COLLECT;
      w_pack_nx    = '0;
      w_idx_nx     = '0;
      w_last_nx    = 1'b0;
      w_addr_nx    = '0;
      w_bytes_nx   = '0;
      w_done_nx    = 1'b0;
      w_err_nx     = 1'b0;
      w_ready_b_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      r_state   <= S_IDLE;
      r_pack    <= '0;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_ready_b <= 1'b1;
      r_ceb     <= 1'b1;
      r_web     <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_bytes   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pack    <= w_pack_nx;
      r_idx     <= w_idx_nx;
      r_last    <= w_last_nx;
      r_ready_b <= w_ready_b_nx;
      r_ceb     <= w_ceb_nx;
      r_web     <= w_web_nx;
      r_addr    <= w_addr_nx;
      r_wdata   <= w_wdata_nx;
      r_bytes   <= w_bytes_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
    end
  end

  assign bus.in_ready_b = r_ready_b;
  assign bus.imem_ceb   = r_ceb;
  assign bus.imem_web   = r_web;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign expectedBytes  = r_bytes;
  assign load_done      = r_done;
  assign load_error     = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a word-level model of the packed stream
// checks every memory write, plus literal checks on loaded words and status.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        resetB;
  logic        load_start_b;
  logic [15:0] expectedBytes;
  logic        load_done;
  logic        load_error;

  imem_loader_if bus();

  imem_loader dut (
    .clk           (clk),
    .resetB        (resetB),
    .load_start_b  (load_start_b),
    .bus           (bus),
    .expectedBytes (expectedBytes),
    .load_done     (load_done),
    .load_error    (load_error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_writes = 0;
  int          rdy_hi = 0;
  int          cyc = 0;
  logic        corrupt = 1'b0;
  logic [7:0]  stim[$];
  logic [31:0] exp_q[$];
  logic [9:0]  exp_a[$];
  logic [31:0] mw   [0:1023];
  logic [31:0] seen [0:1023];
  logic [31:0] mem  [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Expected memory image: byte i lands in word i/4, big-endian, zero-padded.
  task automatic build_model(input int nbytes);
    for (int w = 0; w < 1024; w++) mw[w] = 32'h0;
    for (int i = 0; i < nbytes; i++)
      mw[i/4] = mw[i/4] | (32'(stim[i]) << (8 * (3 - (i % 4))));
    for (int w = 0; w * 4 < nbytes; w++) begin
      exp_q.push_back(mw[w]);
      exp_a.push_back(10'(w));
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory model behind the write port, with optional read corruption.
  always @(posedge clk) begin
    if (!bus.imem_ceb && !bus.imem_web) mem[bus.imem_addr] <= bus.imem_wdata;
    if (!bus.imem_ceb && bus.imem_web)
      bus.imem_rdata <= corrupt ? 32'hDEADBEEF : mem[bus.imem_addr];
  end

  // Per-cycle compare of memory port activity against the model.
  always @(negedge clk) begin
    if (resetB) begin
      if (bus.in_ready_b && !load_done && !load_error) rdy_hi++;
      if (!bus.imem_ceb && !bus.imem_web) begin
        n_writes++;
        seen[bus.imem_addr] = bus.imem_wdata;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          check("wr_addr", 32'(bus.imem_addr), 32'(exp_a.pop_front()));
          check("wr_data", bus.imem_wdata, exp_q.pop_front());
          check("wr_ready_b", 32'(bus.in_ready_b), 32'h1);
        end
      end
`ifndef IMEM_LOADER_READBACK_EN
      if (!bus.imem_ceb && bus.imem_web) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_read: addr 0x%0h", bus.imem_addr);
      end
`endif
    end
  end

  task automatic start_load();
    @(negedge clk) load_start_b = 1'b0;
    @(negedge clk) load_start_b = 1'b1;
  endtask

  task automatic send_stim(input bit use_last);
    for (int i = 0; i < stim.size(); i++) begin
      int w;
      bus.in_valid_b = 1'b0;
      bus.in_data    = stim[i];
      bus.in_last    = use_last && (i == stim.size() - 1);
      w = 0;
      while (bus.in_ready_b !== 1'b0 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        check("accept_timeout", 32'(i), 32'hFFFFFFFF);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid_b = 1'b1;
    bus.in_last    = 1'b0;
  endtask

  task automatic wait_end(output int cycles);
    cycles = 0;
    while (!load_done && !load_error && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 400) check("end_timeout", 32'(cycles), 32'h0);
  endtask

  int c0, cyc_used, wr0;
`ifdef IMEM_LOADER_READBACK_EN
  localparam int EXP_CYC = 21;
  localparam int EXP_RDY = 9;
`else
  localparam int EXP_CYC = 15;
  localparam int EXP_RDY = 3;
`endif

  initial begin
    resetB         = 1'b0;
    load_start_b   = 1'b1;
    bus.in_valid_b = 1'b1;
    bus.in_data    = 8'h00;
    bus.in_last    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready_b", 32'(bus.in_ready_b), 32'h1);
    check("rst_ceb", 32'(bus.imem_ceb), 32'h1);
    check("rst_web", 32'(bus.imem_web), 32'h1);
    check("rst_addr", 32'(bus.imem_addr), 32'h0);
    check("rst_wdata", bus.imem_wdata, 32'h0);
    check("rst_bytes", 32'(expectedBytes), 32'h0);
    check("rst_done", 32'(load_done), 32'h0);
    check("rst_error", 32'(load_error), 32'h0);
    resetB = 1'b1;
    @(negedge clk);

    // 8-byte load
    stim = '{8'h8A, 8'h00, 8'h4F, 8'h00, 8'hD2, 8'hFE, 8'h28, 8'h00};
    build_model(8);
    start_load();
    send_stim(1'b1);
    wait_end(cyc_used);
    check("t1_word0", seen[0], 32'h8A004F00);
    check("t1_word1", seen[1], 32'hD2FE2800);
    check("t1_bytes", 32'(expectedBytes), 32'd8);
    check("t1_done", 32'(load_done), 32'h1);
    check("t1_error", 32'(load_error), 32'h0);

    // 5-byte load, last word padded
    stim = '{8'h38, 8'h00, 8'h6F, 8'h45, 8'h29};
    build_model(5);
    start_load();
    send_stim(1'b1);
    wait_end(cyc_used);
    check("t2_word0", seen[0], 32'h38006F45);
    check("t2_word1", seen[1], 32'h29000000);
    check("t2_bytes", 32'(expectedBytes), 32'd5);
    check("t2_done", 32'(load_done), 32'h1);

    // 12 bytes with valid held low throughout
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'(8'hC0 + i));
    build_model(12);
    start_load();
    c0 = cyc;
    rdy_hi = 0;
    send_stim(1'b1);
    wait_end(cyc_used);
    check("t3_cycles", 32'(cyc - c0), 32'(EXP_CYC));
    check("t3_ready_hi", 32'(rdy_hi), 32'(EXP_RDY));
    check("t3_word2", seen[2], 32'hC8C9CACB);
    check("t3_bytes", 32'(expectedBytes), 32'd12);
    check("t3_pending", 32'(exp_q.size()), 32'h0);

    // 4097-byte overflow
    stim.delete();
    for (int i = 0; i < 4096; i++) stim.push_back(8'((i * 7) + (i >> 8)));
    build_model(4096);
    wr0 = n_writes;
    start_load();
    send_stim(1'b0);
    bus.in_valid_b = 1'b0;
    bus.in_data    = 8'h5A;
    for (int w = 0; w < 20 && !load_error; w++) @(negedge clk);
    check("t4_error", 32'(load_error), 32'h1);
    check("t4_done", 32'(load_done), 32'h0);
    check("t4_ready_b", 32'(bus.in_ready_b), 32'h1);
    check("t4_bytes", 32'(expectedBytes), 32'h1000);
    bus.in_valid_b = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_writes", 32'(n_writes - wr0), 32'd1024);
    check("t4_word1023", seen[1023], mw[1023]);
    check("t4_addr", 32'(bus.imem_addr), 32'h0);

    // Reset in the middle of a load
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    build_model(4);
    start_load();
    send_stim(1'b0);
    resetB = 1'b0;
    #1;
    check("t5_ready_b", 32'(bus.in_ready_b), 32'h1);
    check("t5_ceb", 32'(bus.imem_ceb), 32'h1);
    check("t5_addr", 32'(bus.imem_addr), 32'h0);
    check("t5_wdata", bus.imem_wdata, 32'h0);
    check("t5_bytes", 32'(expectedBytes), 32'h0);
    check("t5_error", 32'(load_error), 32'h0);
    @(negedge clk) resetB = 1'b1;
    stim = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    build_model(4);
    wr0 = n_writes;
    start_load();
    send_stim(1'b1);
    wait_end(cyc_used);
    check("t5_word0", seen[0], 32'hA1B2C3D4);
    check("t5_writes", 32'(n_writes - wr0), 32'd1);
    check("t5_done", 32'(load_done), 32'h1);

`ifdef IMEM_LOADER_READBACK_EN
    // Read-back returns wrong data for the first word
    stim = '{8'h8A, 8'h00, 8'h4F, 8'h00, 8'hD2, 8'hFE, 8'h28, 8'h00};
    build_model(4);
    corrupt = 1'b1;
    start_load();
    send_stim(1'b1);
    wait_end(cyc_used);
    check("t6_error", 32'(load_error), 32'h1);
    check("t6_done", 32'(load_done), 32'h0);
    check("t6_word0", seen[0], 32'h8A004F00);
    check("t6_bytes", 32'(expectedBytes), 32'd4);
    corrupt = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
